// File: rtl/conv_pkg.sv
// conv_pkg: frame geometry defaults, derived constants and sequencer state encoding
package conv_pkg;
    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int K       = 3;
    localparam int RD_LAT  = 1;
    localparam int ENG_LAT = 2;
    localparam int ADDR_W  = 10;
    localparam int OUT_W   = IMG_W - K + 1;
    localparam int OUT_H   = IMG_H - K + 1;
    localparam int PIX_N   = IMG_W * IMG_H;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, FIN} state_t;
endpackage

// File: rtl/conv3x3_align_pipe.sv
// conv3x3_align_pipe: delays {valid,row,col} by DEPTH cycles to line up with engine results
module conv3x3_align_pipe #(
    parameter int DEPTH = 3,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_row,
    input  logic [W-1:0] in_col,
    output logic         out_valid,
    output logic [W-1:0] out_row,
    output logic [W-1:0] out_col
);
    logic [DEPTH-1:0] v;
    logic [W-1:0] r [DEPTH];
    logic [W-1:0] c [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                v[i] <= v[i-1] & ~flush;
                r[i] <= r[i-1];
                c[i] <= c[i-1];
            end
            v[0] <= in_valid & ~flush;
            r[0] <= in_row;
            c[0] <= in_col;
        end
    end
    assign out_valid = v[DEPTH-1];
    assign out_row   = r[DEPTH-1];
    assign out_col   = c[DEPTH-1];
endmodule

// File: rtl/conv3x3_seq_ctrl.sv
// conv3x3_seq_ctrl: streams one frame into the 3x3 engine and flags complete-window results.
// Define CONV3X3_SEQ_ABORT_EN to add the abort input.
module conv3x3_seq_ctrl #(
    parameter int IMG_W   = conv_pkg::IMG_W,
    parameter int IMG_H   = conv_pkg::IMG_H,
    parameter int K       = conv_pkg::K,
    parameter int RD_LAT  = conv_pkg::RD_LAT,
    parameter int ENG_LAT = conv_pkg::ENG_LAT,
    parameter int ADDR_W  = conv_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef CONV3X3_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              eng_rst_n,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_row,
    output logic [ADDR_W-1:0] out_col,
    output logic [ADDR_W-1:0] out_addr
);
    import conv_pkg::*;
    localparam int DEPTH = RD_LAT + ENG_LAT;
    localparam int PIX   = IMG_W * IMG_H;
    state_t state, state_n;
    logic [ADDR_W-1:0] rd_row, rd_col;
    logic [7:0] dcnt;
    logic abort_take, last_pix, win;
    logic pv;
    logic [ADDR_W-1:0] prow, pcol, addr_cnt, hold_row, hold_col, hold_addr;
`ifdef CONV3X3_SEQ_ABORT_EN
    assign abort_take = abort && (state == CLEAR || state == FEED || state == DRAIN);
`else
    assign abort_take = 1'b0;
`endif
    assign last_pix = rd_addr == ADDR_W'(PIX - 1);
    always_comb begin
        state_n   = state;
        busy      = state != IDLE;
        done      = state == FIN;
        rd_en     = state == FEED;
        eng_rst_n = state != CLEAR;
        case (state)
            IDLE:    state_n = start ? CLEAR : IDLE;
            CLEAR:   state_n = FEED;
            FEED:    state_n = last_pix ? DRAIN : FEED;
            DRAIN:   state_n = dcnt == 8'd0 ? FIN : DRAIN;
            default: state_n = IDLE;
        endcase
        if (abort_take)
            state_n = FIN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_addr <= '0;
            rd_row  <= '0;
            rd_col  <= '0;
            dcnt    <= '0;
        end else begin
            state <= state_n;
            if (state == CLEAR) begin
                rd_addr <= '0;
                rd_row  <= '0;
                rd_col  <= '0;
            end else if (state == FEED && !last_pix) begin
                rd_addr <= rd_addr + 1'b1;
                rd_col  <= rd_col == ADDR_W'(IMG_W - 1) ? '0 : rd_col + 1'b1;
                rd_row  <= rd_col == ADDR_W'(IMG_W - 1) ? rd_row + 1'b1 : rd_row;
            end
            dcnt <= state == FEED ? 8'(DEPTH - 1) : (state == DRAIN && dcnt != 8'd0) ? dcnt - 1'b1 : dcnt;
        end
    end
    // A pixel closes a window only once K-1 rows and K-1 columns precede it.
    assign win = state == FEED && rd_row >= ADDR_W'(K - 1) && rd_col >= ADDR_W'(K - 1);
    conv3x3_align_pipe #(.DEPTH(DEPTH), .W(ADDR_W)) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_take),
        .in_valid  (win),
        .in_row    (rd_row - ADDR_W'(K - 1)),
        .in_col    (rd_col - ADDR_W'(K - 1)),
        .out_valid (pv),
        .out_row   (prow),
        .out_col   (pcol)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt  <= '0;
            hold_row  <= '0;
            hold_col  <= '0;
            hold_addr <= '0;
        end else if (state == CLEAR) begin
            addr_cnt <= '0;
        end else if (pv) begin
            addr_cnt  <= addr_cnt + 1'b1;
            hold_row  <= prow;
            hold_col  <= pcol;
            hold_addr <= addr_cnt;
        end
    end
    assign out_valid = pv;
    assign out_row   = pv ? prow : hold_row;
    assign out_col   = pv ? pcol : hold_col;
    assign out_addr  = pv ? addr_cnt : hold_addr;
endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// tb_conv3x3_seq_ctrl: directed frames with a result scoreboard and timing checks
module tb_conv3x3_seq_ctrl;
    import conv_pkg::*;
    typedef struct packed {
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        logic [ADDR_W-1:0] addr;
    } res_t;

    logic clk = 0, rst_n = 0, start = 0, abort = 0;
    logic busy, done, rd_en, eng_rst_n, out_valid;
    logic [ADDR_W-1:0] rd_addr, out_row, out_col, out_addr;

    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0;
    bit active = 0;
    int first_v, last_v, done_at, nv, eng_lows, rd_cnt;
    res_t last_e;
    res_t sb[$];

    conv3x3_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef CONV3X3_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .eng_rst_n (eng_rst_n),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_addr  (out_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        first_v = -1; last_v = -1; done_at = -1; nv = 0; eng_lows = 0; rd_cnt = 0;
    endtask

    task automatic push_frame();
        for (int r = 0; r < OUT_H; r++)
            for (int c = 0; c < OUT_W; c++)
                sb.push_back('{row: ADDR_W'(r), col: ADDR_W'(c), addr: ADDR_W'(r * OUT_W + c)});
    endtask

    // Monitor: scoreboard pops, read address sequence, row-wrap gaps and hold behaviour.
    always @(negedge clk) begin
        int rel;
        res_t e;
        if (rst_n && active) begin
            rel = cyc - t0 + 1;
            if (!eng_rst_n) begin
                eng_lows++;
                chk("eng_rst_n_cycle", rel, 1);
            end
            if (rd_en) begin
                rd_cnt++;
                chk("rd_addr", {22'd0, rd_addr}, rel - 2);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_row", {22'd0, out_row}, {22'd0, e.row});
                    chk("out_col", {22'd0, out_col}, {22'd0, e.col});
                    chk("out_addr", {22'd0, out_addr}, {22'd0, e.addr});
                    if (nv > 0)
                        chk("valid_gap", rel - last_v - 1, e.col == 0 ? 2 : 0);
                    if (nv == 0) first_v = rel;
                    last_v = rel;
                    last_e = e;
                    nv++;
                end
            end else if (nv > 0) begin
                chk("hold_addr", {22'd0, out_addr}, {22'd0, last_e.addr});
                chk("hold_row", {22'd0, out_row}, {22'd0, last_e.row});
            end
            if (done) done_at = rel;
        end
    end

    task automatic begin_frame();
        clear_rec();
        push_frame();
        @(negedge clk); #1;
        start = 1;
        active = 1;
        @(posedge clk); #1;
        t0 = cyc;
    endtask

    task automatic wait_done(input int hold_until, input int p1, input int p2);
        int r;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk); #1;
            r = cyc - t0 + 1;
            if (r == 0) chk("busy_idle_between", {31'd0, busy}, 0);
            start = (r < hold_until) || r == p1 || r == p2;
            if (done_at >= 0) return;
        end
        chk("done_timeout", 1, 0);
    endtask

    task automatic check_frame();
        chk("first_valid_cycle", first_v, 63);
        chk("last_valid_cycle", last_v, 788);
        chk("done_cycle", done_at, 789);
        chk("result_count", nv, OUT_W * OUT_H);
        chk("eng_rst_low_count", eng_lows, 1);
        chk("rd_count", rd_cnt, PIX_N);
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        int r;
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rd_en", {31'd0, rd_en}, 0);
        chk("rst_rd_addr", {22'd0, rd_addr}, 0);
        chk("rst_eng_rst_n", {31'd0, eng_rst_n}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_addr", {22'd0, out_addr}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Frame 1: stray start pulses in FEED and DRAIN must be ignored.
        begin_frame();
        wait_done(1, 100, 787);
        check_frame();
        @(negedge clk); #1;
        chk("busy_after_frame", {31'd0, busy}, 0);
        start = 0;

        // Frames 2 and 3: start held high gives back-to-back frames.
        begin_frame();
        wait_done(100000, -1, -1);
        check_frame();
        clear_rec();
        push_frame();
        t0 = t0 + 790;
        wait_done(5, -1, -1);
        check_frame();
        start = 0;
        @(negedge clk); #1;
        chk("busy_after_b2b", {31'd0, busy}, 0);

        // Frame 4: asynchronous reset mid-frame.
        begin_frame();
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk); #1;
            r = cyc - t0 + 1;
            start = 0;
            if (r == 400) break;
        end
        rst_n = 0;
        #1;
        active = 0;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_rd_en", {31'd0, rd_en}, 0);
        chk("arst_rd_addr", {22'd0, rd_addr}, 0);
        chk("arst_eng_rst_n", {31'd0, eng_rst_n}, 1);
        chk("arst_out_valid", {31'd0, out_valid}, 0);
        chk("arst_out_row", {22'd0, out_row}, 0);
        chk("arst_out_col", {22'd0, out_col}, 0);
        chk("arst_out_addr", {22'd0, out_addr}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("arst_no_done", {31'd0, done}, 0);

        // Frame 5: full frame after reset.
        begin_frame();
        wait_done(1, -1, -1);
        check_frame();

`ifdef CONV3X3_SEQ_ABORT_EN
        begin_frame();
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk); #1;
            r = cyc - t0 + 1;
            start = 0;
            if (r == 300) break;
        end
        abort = 1;
        @(negedge clk); #1;
        abort = 0;
        chk("abort_rd_en", {31'd0, rd_en}, 0);
        chk("abort_done", {31'd0, done}, 1);
        chk("abort_out_valid", {31'd0, out_valid}, 0);
        chk("abort_busy_fin", {31'd0, busy}, 1);
        sb.delete();
        @(negedge clk); #1;
        chk("abort_busy_low", {31'd0, busy}, 0);
        chk("abort_done_once", {31'd0, done}, 0);
        repeat (10) @(negedge clk);
`endif
        active = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
